// File: rtl/cnn_pkg.sv
// Shared types and helpers for the pooling + fully-connected engine.
package cnn_pkg;

    // Window reduction selected for a frame.
    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    // Engine sequencing: collect a frame, run the MAC sweep, flag completion.
    typedef enum logic [1:0] {
        FILL = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    // Ceiling log2, never below 1 so derived counters always have at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pool_window_reduce.sv
// Reduces one 2x2 window of signed activations to a single pooled value.
// Elements arrive as k=0:(0,0) 1:(0,1) 2:(1,0) 3:(1,1).
module pool_window_reduce
    import cnn_pkg::*;
#(
    parameter int DATA_W = 69
) (
    input  logic [4*DATA_W-1:0] win,
    input  pool_mode_e          mode,
    output logic [DATA_W-1:0]   pooled
);

    logic signed [DATA_W-1:0] elem [4];
    logic signed [DATA_W-1:0] best;
    logic signed [DATA_W+1:0] sum;

    // Max scans in window order with a strict compare so ties keep the earlier element;
    // average sums in two extra bits and floors via the arithmetic shift.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            elem[k] = win[k*DATA_W +: DATA_W];
        end
        best = elem[0];
        for (int k = 1; k < 4; k++) begin
            if (elem[k] > best) begin
                best = elem[k];
            end
        end
        sum = (DATA_W+2)'(elem[0]) + (DATA_W+2)'(elem[1])
            + (DATA_W+2)'(elem[2]) + (DATA_W+2)'(elem[3]);
        if (mode == POOL_AVG) begin
            pooled = DATA_W'(sum >>> 2);
        end else begin
            pooled = best;
        end
    end

endmodule

// File: rtl/pool_fc_engine.sv
// Pools one 2x2 window per channel per accepted beat into a frame buffer, then sweeps
// every buffered feature through N_CLASS multiply-accumulators fed by an external weight ROM.
module pool_fc_engine
    import cnn_pkg::*;
#(
    parameter  int CH      = 8,
    parameter  int DATA_W  = 69,
    parameter  int POOL_X  = 12,
    parameter  int POOL_Y  = 12,
    parameter  int N_CLASS = 10,
    parameter  int W_W     = 32,
    parameter  int ACC_W   = 113,
    localparam int N_POS   = POOL_X * POOL_Y,
    localparam int N_FEAT  = CH * N_POS,
    localparam int FA_W    = clog2(N_FEAT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       pool_mode,
    input  logic [CH*4*DATA_W-1:0]     win_data,
    output logic                       pool_valid,
    output logic [CH*DATA_W-1:0]       pool_data,
    output logic                       w_rd_en,
    output logic [FA_W-1:0]            w_addr,
    input  logic [N_CLASS*W_W-1:0]     w_data,
    output logic [N_CLASS*ACC_W-1:0]   prob,
    output logic                       prob_valid,
    output logic                       fc_done
);

    localparam int POS_W = clog2(N_POS);
    localparam int CH_W  = clog2(CH);

    fsm_state_e state, state_nxt;
    logic       start_mac;
    logic       finish_mac;

    logic                   accept;
    logic                   last_beat;
    logic [POS_W-1:0]       pos_cnt;
    pool_mode_e             mode_q;
    pool_mode_e             mode_eff;
    logic [CH*DATA_W-1:0]   pooled_now;
    logic [CH*DATA_W-1:0]   fbuf [N_POS];

    logic [CH_W-1:0]          iss_ch;
    logic [POS_W-1:0]         iss_pos;
    logic                     issue_last;
    logic [CH*DATA_W-1:0]     feat_row;
    logic signed [DATA_W-1:0] feat_rd;
    logic signed [DATA_W-1:0] feat_q;
    logic                     acc_en_q;
    logic                     acc_last_q;

    logic signed [ACC_W-1:0]  w_ext;
    logic signed [ACC_W-1:0]  f_ext;
    logic [ACC_W-1:0]         mac_sum [N_CLASS];

    assign in_ready   = (state == FILL);
    assign accept     = in_valid && in_ready;
    assign last_beat  = (pos_cnt == POS_W'(N_POS - 1));
    assign mode_eff   = (pos_cnt == '0) ? pool_mode_e'(pool_mode) : mode_q;
    assign issue_last = w_rd_en && (iss_ch == CH_W'(CH - 1)) && (iss_pos == POS_W'(N_POS - 1));

    for (genvar c = 0; c < CH; c++) begin : g_reduce
        pool_window_reduce #(
            .DATA_W (DATA_W)
        ) u_reduce (
            .win    (win_data[c*4*DATA_W +: 4*DATA_W]),
            .mode   (mode_eff),
            .pooled (pooled_now[c*DATA_W +: DATA_W])
        );
    end

    // Next-state: leave FILL on the final beat, leave MAC once the last product is summed.
    always_comb begin
        state_nxt  = state;
        start_mac  = 1'b0;
        finish_mac = 1'b0;
        case (state)
            FILL: begin
                if (accept && last_beat) begin
                    state_nxt = MAC;
                    start_mac = 1'b1;
                end
            end
            MAC: begin
                if (acc_last_q) begin
                    state_nxt  = DONE;
                    finish_mac = 1'b1;
                end
            end
            DONE: begin
                state_nxt = FILL;
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Raster position, frame mode latch and the registered copy of each pooled beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_cnt    <= '0;
            mode_q     <= POOL_MAX;
            pool_valid <= 1'b0;
            pool_data  <= '0;
        end else begin
            pool_valid <= accept;
            if (accept) begin
                pool_data <= pooled_now;
                pos_cnt   <= last_beat ? '0 : pos_cnt + POS_W'(1);
                if (pos_cnt == '0) begin
                    mode_q <= mode_eff;
                end
            end
        end
    end

    // Frame buffer write; contents are only meaningful once a full frame has been collected.
    always_ff @(posedge clk) begin
        if (accept) begin
            fbuf[pos_cnt] <= pooled_now;
        end
    end

    // Select the feature for the current issue so its registered copy lines up with w_data.
    always_comb begin
        feat_row = fbuf[iss_pos];
        feat_rd  = feat_row[iss_ch*DATA_W +: DATA_W];
    end

    // Issue sequencer: walks f = ch*N_POS + pos with channel outer, one address per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_rd_en    <= 1'b0;
            w_addr     <= '0;
            iss_ch     <= '0;
            iss_pos    <= '0;
            feat_q     <= '0;
            acc_en_q   <= 1'b0;
            acc_last_q <= 1'b0;
        end else begin
            acc_en_q   <= w_rd_en;
            acc_last_q <= issue_last;
            if (w_rd_en) begin
                feat_q <= feat_rd;
            end
            if (start_mac) begin
                w_rd_en <= 1'b1;
                w_addr  <= '0;
                iss_ch  <= '0;
                iss_pos <= '0;
            end else if (w_rd_en) begin
                if (issue_last) begin
                    w_rd_en <= 1'b0;
                end else begin
                    w_addr <= w_addr + FA_W'(1);
                    if (iss_pos == POS_W'(N_POS - 1)) begin
                        iss_pos <= '0;
                        iss_ch  <= iss_ch + CH_W'(1);
                    end else begin
                        iss_pos <= iss_pos + POS_W'(1);
                    end
                end
            end
        end
    end

    // Per-class running sums; sign-extended operands and modulo-2^ACC_W wraparound.
    always_comb begin
        w_ext = '0;
        f_ext = ACC_W'(feat_q);
        for (int n = 0; n < N_CLASS; n++) begin
            w_ext      = ACC_W'($signed(w_data[n*W_W +: W_W]));
            mac_sum[n] = prob[n*ACC_W +: ACC_W] + ACC_W'(w_ext * f_ext);
        end
    end

    // Score registers: cleared on MAC entry, held after completion until the next frame's MAC.
    always_ff @(posedge clk) begin
        if (rst) begin
            prob       <= '0;
            prob_valid <= 1'b0;
            fc_done    <= 1'b0;
        end else begin
            fc_done <= finish_mac;
            if (start_mac) begin
                prob       <= '0;
                prob_valid <= 1'b0;
            end else begin
                if (acc_en_q) begin
                    for (int n = 0; n < N_CLASS; n++) begin
                        prob[n*ACC_W +: ACC_W] <= mac_sum[n];
                    end
                end
                if (finish_mac) begin
                    prob_valid <= 1'b1;
                end
            end
        end
    end

endmodule
